uart_rx_fifo: RTL and testbench

Parametrised UART receiver for the lightcube host link. It replaces the fixed 8N1 `uart_rx` with configurable data width, parity, stop-bit checking and 16x oversampling. Received words are buffered in a first-word-fall-through FIFO and drained through a valid/ready handshake. It sits between the board `rx` pin and the frame/command decoder that fills the cube frame buffer.

---
 rtl/uart_rx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver for the lightcube host link. It has 16x oversampling, configurable
// data width and parity, and checks the stop bit. Good words are queued in a
// first-word-fall-through FIFO, which the consumer drains with a valid/ready
// handshake.
//
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of
// the samples at oversample ticks 7, 8 and 9. The decision is then made at tick 9. If
// the macro is not defined, each bit is a single sample taken at tick 8.

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_100M,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    // Oversample divisor, rounded to the nearest integer (100 MHz / 115200 -> 54).
    localparam int DIV   = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and start-edge detect
    // ------------------------------------------------------------------
    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    logic [1:0] sync_fill;
    logic       line_armed;
    logic       fall_edge;

    // Two-flop synchronizer. The edge detector is armed only after a real high has been seen.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            sync_fill  <= '0;
            line_armed <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            // rx_sync holds a genuine line sample once sync_fill[1] is set. The reset value
            // of 1 therefore cannot fake an idle line: a line held low through reset needs a
            // fresh falling edge before it can start a frame.
            if (sync_fill[1] && rx_sync) begin
                line_armed <= 1'b1;
            end
        end
    end

    assign fall_edge = line_armed && rx_prev && !rx_sync;

    // ------------------------------------------------------------------
    // Oversample tick generation
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_cnt;
    logic [3:0]       tick_next;
    logic             tick;
    logic             cnt_clear;

    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign tick_next = tick_cnt + 4'd1;

    // Divisor and per-bit tick counters. Both restart on the start edge so that
    // tick 8 lands mid-bit.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (cnt_clear) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= tick_next;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Bit decision
    // ------------------------------------------------------------------
    logic sample_stb;
    logic sample_val;

`ifdef UART_RX_MAJORITY_EN
    logic vote_7;
    logic vote_8;

    // Keep the tick-7 and tick-8 samples. The tick-9 sample arrives live.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            vote_7 <= 1'b1;
            vote_8 <= 1'b1;
        end else if (tick) begin
            if (tick_next == 4'd7) begin
                vote_7 <= rx_sync;
            end
            if (tick_next == 4'd8) begin
                vote_8 <= rx_sync;
            end
        end
    end

    assign sample_stb = tick && (tick_next == 4'd9);
    assign sample_val = (vote_7 & vote_8) | (vote_7 & rx_sync) | (vote_8 & rx_sync);
`else
    assign sample_stb = tick && (tick_next == 4'd8);
    assign sample_val = rx_sync;
`endif

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               last_bit;
    logic               shift_en;
    logic               par_load;
    logic               stop_eval;

    assign last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));

    // State register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Every decision happens on the mid-bit sample strobe.
    // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // A high mid-start sample was a glitch. Drop it without raising a flag.
                if (sample_stb) begin
                    state_nxt = sample_val ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_stb && last_bit) begin
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample_stb) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a start bit that follows straight away is still caught.
                if (sample_stb) begin
                    state_nxt = sample_val ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A held-low line reports one frame error, then waits here for idle.
                if (rx_sync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        cnt_clear = 1'b0;
        shift_en  = 1'b0;
        par_load  = 1'b0;
        stop_eval = 1'b0;
        case (state)
            S_IDLE:   cnt_clear = fall_edge;
            S_DATA:   shift_en  = sample_stb;
            S_PARITY: par_load  = sample_stb;
            S_STOP:   stop_eval = sample_stb;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter and parity check
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bad;
    logic                 par_xor;

    assign par_xor = (^shift_reg) ^ sample_val;

    // Data bits arrive LSB first. Each one enters at the MSB, so the first bit ends up at bit 0.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bad   <= 1'b0;
        end else begin
            if (cnt_clear) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end else if (shift_en) begin
                shift_reg <= {sample_val, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + BIT_W'(1);
            end
            // Even parity expects an overall XOR of 0. Odd parity expects 1.
            if (par_load) begin
                par_bad <= (PARITY == 2) ? !par_xor : par_xor;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stop-bit verdict: status pulses and the FIFO push request
    // ------------------------------------------------------------------
    logic                 push_req;
    logic [DATA_BITS-1:0] push_word;

    // Register the verdict one cycle after the mid-stop strobe. Every output here lasts exactly one cycle.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            push_req   <= 1'b0;
            push_word  <= '0;
        end else begin
            frame_err  <= stop_eval && !sample_val;
            parity_err <= stop_eval && sample_val && par_bad;
            push_req   <= stop_eval && sample_val && !par_bad;
            if (stop_eval) begin
                push_word <= shift_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;

    assign rx_valid  = (fifo_count != '0);
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop       = rx_valid && rx_ready;
    // A full FIFO still takes the word if a pop frees the head slot in the same cycle.
    assign push      = push_req && (!fifo_full || pop);
    assign overrun   = push_req && fifo_full && !pop;
    assign rx_data   = rx_valid ? mem[rd_ptr] : '0;

    // Storage array write port.
    // NOTE: the storage array has no reset. rx_data is forced to zero while empty, so stale
    //       entries are never visible.
    always_ff @(posedge clk_100M) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers wrap naturally because the depth is a power of two. The count tracks occupancy.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. It drives two instances from one clock.
//   dut_a : 8N1, FIFO_DEPTH 4
//   dut_b : 8E1 (even parity), FIFO_DEPTH 4
// Both instances run at CLK_FREQ 8 MHz and BAUD 100 kbit/s. The divisor is
// (8.0M + 0.8M) / 1.6M = 5.5, which rounds down to 5, so one bit lasts 80 clocks.
// Expected words go onto per-instance queues and are compared as the consumer pops them.

module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 8_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 80;

    logic       clk;
    logic       rst_n;

    logic       rx_a, rx_ready_a, rx_valid_a, ferr_a, perr_a, ovr_a;
    logic [7:0] rx_data_a;
    logic [2:0] cnt_a;

    logic       rx_b, rx_ready_b, rx_valid_b, ferr_b, perr_b, ovr_b;
    logic [7:0] rx_data_b;
    logic [2:0] cnt_b;

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
    ) dut_a (
        .clk_100M(clk), .rst_n(rst_n), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a), .fifo_count(cnt_a)
    );

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk_100M(clk), .rst_n(rst_n), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b), .fifo_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp_qa[$];
    logic [7:0] exp_qb[$];
    logic [7:0] head_a, head_b;

    int ferr_n_a = 0, perr_n_a = 0, ovr_n_a = 0, multi_a = 0;
    int ferr_n_b = 0, perr_n_b = 0, ovr_n_b = 0;
    logic pf_a = 0, pp_a = 0, po_a = 0, pf_b = 0, pp_b = 0, po_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_chk(input string name, input logic cur, input logic prev);
        if (cur && prev) begin
            n_bad++;
            $display("FAIL %s: high for 2+ cycles, required a 1-cycle pulse", name);
        end
    endtask

    // Monitor, sampling on the falling edge. It compares words as they are popped,
    // counts status pulses and checks that each pulse is one cycle wide.
    always @(negedge clk) begin
        if (rx_valid_a && rx_ready_a) begin
            if (exp_qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_a_extra: got 0x%0h, required no word", rx_data_a);
            end else begin
                head_a = exp_qa.pop_front();
                check("sb_a_word", 32'(rx_data_a), 32'(head_a));
            end
        end
        if (rx_valid_b && rx_ready_b) begin
            if (exp_qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_b_extra: got 0x%0h, required no word", rx_data_b);
            end else begin
                head_b = exp_qb.pop_front();
                check("sb_b_word", 32'(rx_data_b), 32'(head_b));
            end
        end
        if (cnt_a >= 3'd2) multi_a++;
        if (ferr_a) ferr_n_a++;
        if (perr_a) perr_n_a++;
        if (ovr_a)  ovr_n_a++;
        if (ferr_b) ferr_n_b++;
        if (perr_b) perr_n_b++;
        if (ovr_b)  ovr_n_b++;
        pulse_chk("ferr_a_width", ferr_a, pf_a);
        pulse_chk("perr_a_width", perr_a, pp_a);
        pulse_chk("ovr_a_width",  ovr_a,  po_a);
        pulse_chk("ferr_b_width", ferr_b, pf_b);
        pulse_chk("perr_b_width", perr_b, pp_b);
        pulse_chk("ovr_b_width",  ovr_b,  po_b);
        pf_a = ferr_a; pp_a = perr_a; po_a = ovr_a;
        pf_b = ferr_b; pp_b = perr_b; po_b = ovr_b;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. All inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input bit line_b, input logic v, input int clks);
        if (line_b) rx_b = v;
        else        rx_a = v;
        step(clks);
    endtask

    task automatic send_frame(input bit line_b, input logic [7:0] data,
                              input bit with_par, input logic par, input logic stop);
        hold_bit(line_b, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_bit(line_b, data[i], BIT_CLKS);
        if (with_par) hold_bit(line_b, par, BIT_CLKS);
        hold_bit(line_b, stop, BIT_CLKS);
    endtask

    task automatic drain_a(input string name);
        rx_ready_a = 1'b1;
        for (int i = 0; i < 40 && exp_qa.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check({name, "_left"}, 32'(exp_qa.size()), 32'd0);
        check({name, "_count"}, 32'(cnt_a), 32'd0);
    endtask

    // Parity table for dut_b: frame inputs, then the expected count and parity-error pulses.
    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stored;
        int         exp_count;
        int         exp_perr;
    } vec_t;

    vec_t vecs [6];

    int base_f, base_p, base_o, base_m;

    initial begin
        vecs[0] = '{8'h0F, 1'b0, 1'b1, 1, 0};  // even count of ones, parity 0: good
        vecs[1] = '{8'h0F, 1'b1, 1'b0, 1, 1};  // parity 1 is wrong for 0x0F
        vecs[2] = '{8'h01, 1'b1, 1'b1, 2, 0};  // odd count of ones needs parity 1
        vecs[3] = '{8'h01, 1'b0, 1'b0, 2, 1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 3, 0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 4, 0};

        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        rx_ready_a = 1'b0; rx_ready_b = 1'b0;

        // ---- Reset values ----
        repeat (3) @(negedge clk);
        check("rst_valid_a", 32'(rx_valid_a), 32'd0);
        check("rst_data_a",  32'(rx_data_a),  32'd0);
        check("rst_count_a", 32'(cnt_a),      32'd0);
        check("rst_flags_a", 32'({ferr_a, perr_a, ovr_a}), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(10);

        // ---- 8N1, back-to-back frames 0xBF then 0x90, consumer always ready ----
        rx_ready_a = 1'b1;
        base_m = multi_a;
        exp_qa.push_back(8'hBF);
        exp_qa.push_back(8'h90);
        send_frame(1'b0, 8'hBF, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h90, 1'b0, 1'b0, 1'b1);
        step(BIT_CLKS);
        @(negedge clk);
        check("t1_left",    32'(exp_qa.size()), 32'd0);
        check("t1_one_cyc", 32'(multi_a - base_m), 32'd0);
        check("t1_no_errs", 32'(ferr_n_a + perr_n_a + ovr_n_a), 32'd0);

        // ---- Parity table on dut_b, consumer stalled ----
        for (int v = 0; v < 6; v++) begin
            base_p = perr_n_b;
            if (vecs[v].stored) exp_qb.push_back(vecs[v].data);
            step(1);
            send_frame(1'b1, vecs[v].data, 1'b1, vecs[v].par, 1'b1);
            @(negedge clk);
            check($sformatf("par_count_%0d", v), 32'(cnt_b), 32'(vecs[v].exp_count));
            check($sformatf("par_perr_%0d", v), 32'(perr_n_b - base_p), 32'(vecs[v].exp_perr));
        end
        step(1);
        rx_ready_b = 1'b1;
        for (int i = 0; i < 40 && exp_qb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("par_left",  32'(exp_qb.size()), 32'd0);
        check("par_count", 32'(cnt_b), 32'd0);
        check("par_other", 32'(ferr_n_b + ovr_n_b), 32'd0);

        // ---- Stop bit low, then the line is held low for 20 bit times ----
        step(1);
        base_f = ferr_n_a;
        base_p = perr_n_a;
        hold_bit(1'b0, 1'b0, 30 * BIT_CLKS);
        hold_bit(1'b0, 1'b1, 2 * BIT_CLKS);
        @(negedge clk);
        check("brk_ferr",  32'(ferr_n_a - base_f), 32'd1);
        check("brk_count", 32'(cnt_a), 32'd0);
        exp_qa.push_back(8'h55);
        step(1);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        step(BIT_CLKS);
        @(negedge clk);
        check("brk_next",  32'(exp_qa.size()), 32'd0);
        check("brk_nopar", 32'(perr_n_a - base_p), 32'd0);

        // ---- Overrun: stalled consumer, five words into a four-entry FIFO ----
        step(1);
        rx_ready_a = 1'b0;
        base_o = ovr_n_a;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_qa.push_back(8'(k));
            send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        check("ovr_count", 32'(cnt_a), 32'd4);
        check("ovr_pulse", 32'(ovr_n_a - base_o), 32'd1);
        check("ovr_head",  32'(rx_data_a), 32'h01);
        check("ovr_valid", 32'(rx_valid_a), 32'd1);
        step(1);
        drain_a("ovr_drain");

        // ---- 300 ns glitch while idle ----
        step(1);
        base_f = ferr_n_a;
        base_p = perr_n_a;
        hold_bit(1'b0, 1'b0, 30);
        hold_bit(1'b0, 1'b1, BIT_CLKS - 30);
        @(negedge clk);
        check("glitch_count", 32'(cnt_a), 32'd0);
        check("glitch_errs",  32'((ferr_n_a - base_f) + (perr_n_a - base_p)), 32'd0);
        exp_qa.push_back(8'h3C);
        step(1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        step(BIT_CLKS);
        @(negedge clk);
        check("glitch_next", 32'(exp_qa.size()), 32'd0);

        // ---- Reset mid-DATA with two words stored ----
        step(1);
        rx_ready_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("rst2_count_pre", 32'(cnt_a), 32'd2);
        step(1);
        hold_bit(1'b0, 1'b0, BIT_CLKS);        // start bit
        hold_bit(1'b0, 1'b1, BIT_CLKS);        // d0
        hold_bit(1'b0, 1'b0, BIT_CLKS / 2);    // halfway through d1, line low
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst2_valid", 32'(rx_valid_a), 32'd0);
        check("rst2_count", 32'(cnt_a), 32'd0);
        check("rst2_data",  32'(rx_data_a), 32'd0);
        check("rst2_flags", 32'({ferr_a, perr_a, ovr_a}), 32'd0);
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        // The line is still low after release, which must not count as a start.
        rx_ready_a = 1'b1;
        hold_bit(1'b0, 1'b0, 100);
        hold_bit(1'b0, 1'b1, 2 * BIT_CLKS);
        exp_qa.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        step(BIT_CLKS);
        @(negedge clk);
        check("rst2_next",  32'(exp_qa.size()), 32'd0);
        check("rst2_final", 32'(cnt_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
